// File: rtl/ex_pkg.sv
// Shared types for the execute-stage result register: exception codes,
// the buffered entry layout and the skid-buffer occupancy encoding.
package ex_pkg;

  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_NONE = 5'h00;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] pc;
    logic [4:0]  wdest;
    logic        wen;
    logic        exc;
    logic [4:0]  exc_code;
  } ex_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_result_stage_if.sv
// ALU-to-memory-stage handshake bundle for ex_result_stage.
// The fwd_* bypass signals exist only when EX_FWD_EN is defined.
interface ex_result_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic        in_overflow;
  logic        in_trap_en;
  logic        in_wen;
  logic [4:0]  in_wdest;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_pc;
  logic        out_wen;
  logic [4:0]  out_wdest;
  logic        out_exc;
  logic [4:0]  out_exc_code;
`ifdef EX_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_wdest;
  logic [31:0] fwd_data;
`endif

  modport master (
`ifdef EX_FWD_EN
    input  fwd_valid, fwd_wdest, fwd_data,
`endif
    output in_valid, in_alu_out, in_overflow, in_trap_en, in_wen, in_wdest, in_pc,
    output flush, out_ready,
    input  in_ready, out_valid, out_result, out_pc, out_wen, out_wdest,
    input  out_exc, out_exc_code
  );

  modport slave (
`ifdef EX_FWD_EN
    output fwd_valid, fwd_wdest, fwd_data,
`endif
    input  in_valid, in_alu_out, in_overflow, in_trap_en, in_wen, in_wdest, in_pc,
    input  flush, out_ready,
    output in_ready, out_valid, out_result, out_pc, out_wen, out_wdest,
    output out_exc, out_exc_code
  );

endinterface

// File: rtl/ex_skid_buf.sv
// Two-entry in-order skid buffer for ex_entry_t. slot0 is always the head;
// in_ready is registered from the next occupancy so it never sees out_ready.
module ex_skid_buf
  import ex_pkg::*;
(
  input  logic      clk,
  input  logic      resetn,
  input  logic      flush,
  input  logic      in_valid,
  output logic      in_ready,
  input  ex_entry_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
`ifdef EX_FWD_EN
  output ex_entry_t slot1_data,
  output logic      full,
`endif
  output ex_entry_t out_data
);

  occ_e      state_q, state_d;
  ex_entry_t slot0_q, slot0_d;
  ex_entry_t slot1_q, slot1_d;
  logic      in_ready_q, in_ready_d;
  logic      acc, deq;

  assign acc       = in_valid && in_ready_q;
  assign deq       = out_valid && out_ready;
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = slot0_q;
`ifdef EX_FWD_EN
  assign slot1_data = slot1_q;
  assign full       = (state_q == OCC_FULL);
`endif

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (acc) begin
          slot0_d = in_data;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && deq) begin
          slot0_d = in_data;
        end else if (acc) begin
          slot1_d = in_data;
          state_d = OCC_FULL;
        end else if (deq) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (deq) begin
          slot0_d = slot1_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Squash wins over any same-cycle accept; a same-cycle dequeue already left.
    if (flush) state_d = OCC_EMPTY;
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= OCC_EMPTY;
      slot0_q    <= '0;
      slot1_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result register: Ov exception capture, trap fence and skid buffer.
// Optional macro EX_FWD_EN adds the fwd_* bypass outputs for the decode stage.
module ex_result_stage
  import ex_pkg::*;
(
  input logic             clk,
  input logic             resetn,
  ex_result_stage_if.slave bus
);

  logic      fence_q, fence_d;
  logic      buf_in_valid, buf_in_ready;
  ex_entry_t in_entry, head;

  function automatic ex_entry_t capture_entry(
    input logic [31:0] result,
    input logic [31:0] pc,
    input logic [4:0]  wdest,
    input logic        wen,
    input logic        ovf,
    input logic        trap_en
  );
    ex_entry_t e;
    e.result   = result;
    e.pc       = pc;
    e.wdest    = wdest;
    e.exc      = ovf && trap_en;
    e.wen      = wen && !e.exc;
    e.exc_code = e.exc ? EXC_OV : EXC_NONE;
    return e;
  endfunction

  assign in_entry = capture_entry(bus.in_alu_out, bus.in_pc, bus.in_wdest,
                                  bus.in_wen, bus.in_overflow, bus.in_trap_en);

  // The fence blocks everything younger than an accepted trap until flush.
  assign buf_in_valid = bus.in_valid && !fence_q;
  assign bus.in_ready = buf_in_ready && !fence_q;

  always_comb begin
    fence_d = fence_q;
    if (bus.flush) fence_d = 1'b0;
    else if (buf_in_valid && buf_in_ready && in_entry.exc) fence_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fence_q <= 1'b0;
    else         fence_q <= fence_d;
  end

`ifdef EX_FWD_EN
  ex_entry_t slot1;
  logic      full;
`endif

  ex_skid_buf u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (bus.flush),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
`ifdef EX_FWD_EN
    .slot1_data(slot1),
    .full      (full),
`endif
    .out_data  (head)
  );

  assign bus.out_result   = head.result;
  assign bus.out_pc       = head.pc;
  assign bus.out_wen      = head.wen;
  assign bus.out_wdest    = head.wdest;
  assign bus.out_exc      = head.exc;
  assign bus.out_exc_code = head.exc_code;

`ifdef EX_FWD_EN
  // Youngest writer wins; exc entries carry wen=0 so they never forward.
  always_comb begin
    bus.fwd_valid = 1'b0;
    bus.fwd_wdest = '0;
    bus.fwd_data  = '0;
    if (full && slot1.wen) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_wdest = slot1.wdest;
      bus.fwd_data  = slot1.result;
    end else if (bus.out_valid && head.wen) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_wdest = head.wdest;
      bus.fwd_data  = head.result;
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: a negedge monitor models occupancy,
// the trap fence and forwarding, and compares every head entry in FIFO order.
`timescale 1ns/1ps
module tb_ex_result_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic mon_en;
  logic fence_m;
  logic rnd_done;
  int   n_chk  = 0;
  int   n_fail = 0;
  ex_entry_t exp_q[$];

  always #5 clk = ~clk;

  ex_result_stage_if bus();

  ex_result_stage dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic ex_entry_t model_entry();
    ex_entry_t e;
    logic      trap;
    trap       = bus.in_overflow && bus.in_trap_en;
    e.result   = bus.in_alu_out;
    e.pc       = bus.in_pc;
    e.wdest    = bus.in_wdest;
    e.wen      = bus.in_wen && !trap;
    e.exc      = trap;
    e.exc_code = trap ? 5'h0C : 5'h00;
    return e;
  endfunction

  function automatic ex_entry_t observed();
    ex_entry_t e;
    e.result   = bus.out_result;
    e.pc       = bus.out_pc;
    e.wdest    = bus.out_wdest;
    e.wen      = bus.out_wen;
    e.exc      = bus.out_exc;
    e.exc_code = bus.out_exc_code;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    logic        acc, deq;
    logic        fv;
    logic [4:0]  fw;
    logic [31:0] fd;
    if (resetn && mon_en) begin
      check("in_ready", 80'(bus.in_ready), 80'((exp_q.size() < 2) && !fence_m));
      check("out_valid", 80'(bus.out_valid), 80'(exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) check("head", 80'(observed()), 80'(exp_q[0]));
`ifdef EX_FWD_EN
      fv = 1'b0; fw = '0; fd = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].wen) begin
          fv = 1'b1; fw = exp_q[i].wdest; fd = exp_q[i].result;
        end
      end
      check("fwd", 80'({bus.fwd_valid, bus.fwd_wdest, bus.fwd_data}), 80'({fv, fw, fd}));
`endif
      acc = bus.in_valid && bus.in_ready;
      deq = bus.out_valid && bus.out_ready;
      if (deq && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus.flush) begin
        exp_q.delete();
        fence_m = 1'b0;
      end else if (acc) begin
        exp_q.push_back(model_entry());
        if (exp_q[exp_q.size()-1].exc) fence_m = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Holds the entry on the bus until the stage takes it (bounded).
  task automatic send(input logic [31:0] alu, input logic ov, input logic trap,
                      input logic wen, input logic [4:0] wd, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_alu_out  = alu;
    bus.in_overflow = ov;
    bus.in_trap_en  = trap;
    bus.in_wen      = wen;
    bus.in_wdest    = wd;
    bus.in_pc       = pc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = bus.in_ready;
      step();
    end
    check("send_accepted", 80'(done), 80'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; mon_en = 1'b0; fence_m = 1'b0; rnd_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_alu_out = '0; bus.in_overflow = 1'b0;
    bus.in_trap_en = 1'b0; bus.in_wen = 1'b0; bus.in_wdest = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_out_valid", 80'(bus.out_valid), 80'(0));
    check("rst_in_ready", 80'(bus.in_ready), 80'(1));
    check("rst_out_data", 80'(observed()), 80'(0));
`ifdef EX_FWD_EN
    check("rst_fwd", 80'({bus.fwd_valid, bus.fwd_wdest, bus.fwd_data}), 80'(0));
`endif
    resetn = 1'b1;
    mon_en = 1'b1;
    step();

    // Streaming at full rate
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'h11 * i, 1'b0, 1'b0, 1'b1, 5'(i), 32'h400 + 32'(4 * i));
    idle(3);

    // Back-pressure: A, B buffered, C held until drain
    bus.out_ready = 1'b0;
    send(32'hA, 1'b0, 1'b0, 1'b1, 5'd1, 32'h500);
    send(32'hB, 1'b0, 1'b0, 1'b1, 5'd2, 32'h504);
    fork
      send(32'hC, 1'b0, 1'b0, 1'b1, 5'd3, 32'h508);
      begin
        repeat (3) step();
        check("full_in_ready", 80'(bus.in_ready), 80'(0));
        bus.out_ready = 1'b1;
      end
    join
    idle(4);

    // Trapping overflow: exception entry and fence
    send(32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd5, 32'h600);
    check("exc_flag", 80'({bus.out_exc, bus.out_exc_code, bus.out_wen}), 80'({1'b1, 5'h0C, 1'b0}));
    check("exc_pc", 80'(bus.out_pc), 80'(32'h600));
    idle(3);
    check("fence_hold", 80'(bus.in_ready), 80'(0));
    bus.in_valid = 1'b1; bus.in_trap_en = 1'b0; bus.in_alu_out = 32'hDEAD;
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("fence_clear", 80'(bus.in_ready), 80'(1));
    idle(2);

    // Non-trapping overflow passes untouched
    send(32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd5, 32'h700);
    check("notrap", 80'({bus.out_exc, bus.out_wen, bus.out_wdest}), 80'({1'b0, 1'b1, 5'd5}));
    idle(3);

    // Flush a full buffer with a competing input
    bus.out_ready = 1'b0;
    send(32'h1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h800);
    send(32'h2, 1'b0, 1'b0, 1'b0, 5'd2, 32'h804);
    bus.in_valid = 1'b1; bus.in_alu_out = 32'h99; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_valid", 80'(bus.out_valid), 80'(0));
    check("flush_in_ready", 80'(bus.in_ready), 80'(1));
    bus.out_ready = 1'b1;
    idle(3);

`ifdef EX_FWD_EN
    // Forwarding: youngest writer, and exc entries never forward
    bus.out_ready = 1'b0;
    send(32'h10, 1'b0, 1'b0, 1'b1, 5'd3, 32'h900);
    send(32'h20, 1'b0, 1'b0, 1'b1, 5'd3, 32'h904);
    idle(0);
    check("fwd_young", 80'({bus.fwd_valid, bus.fwd_wdest, bus.fwd_data}), 80'({1'b1, 5'd3, 32'h20}));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("fwd_after_pop", 80'(bus.fwd_data), 80'(32'h20));
    bus.out_ready = 1'b1;
    idle(2);
    bus.out_ready = 1'b0;
    send(32'h7777, 1'b1, 1'b1, 1'b1, 5'd7, 32'hA00);
    idle(0);
    check("fwd_exc", 80'(bus.fwd_valid), 80'(0));
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle(2);
`endif

    // Random stream with random back-pressure
    fork
      begin
        for (int i = 0; i < 100; i++)
          send($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 32'h1000 + 32'(4 * i));
        idle(0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    bus.out_ready = 1'b1;
    idle(4);
    check("drained", 80'(exp_q.size()), 80'(0));

    // Asynchronous reset mid-transfer
    bus.out_ready = 1'b0;
    send(32'h55, 1'b0, 1'b0, 1'b1, 5'd4, 32'hB00);
    send(32'h66, 1'b0, 1'b0, 1'b1, 5'd4, 32'hB04);
    idle(0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", 80'(bus.out_valid), 80'(0));
    check("arst_in_ready", 80'(bus.in_ready), 80'(1));
    check("arst_out_data", 80'(observed()), 80'(0));
    exp_q.delete();
    fence_m = 1'b0;
    step();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h77, 1'b0, 1'b0, 1'b1, 5'd9, 32'hC00);
    idle(3);
    check("final_drained", 80'(exp_q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
